// File: rtl/tt_um_ccmed_morse_translator_pkg.sv
// Shared constants, symbol type and press classifier for the Morse translator.
package morse_pkg;

  localparam int DOT_DASH_THRESH = 2;
  localparam int LETTER_GAP      = 3;
  localparam int WORD_GAP        = 7;
  localparam int MAX_SYMBOLS     = 5;

  localparam logic [7:0] ASCII_ERR   = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [2:0] PRESS_SAT   = 3'd7;

  typedef enum logic [1:0] {
    SYM_NONE,
    SYM_DOT,
    SYM_DASH
  } sym_t;

  // A press of zero ticks is a glitch and produces no symbol.
  function automatic sym_t classify(input logic [2:0] ticks);
    if (ticks == 3'd0)
      return SYM_NONE;
    else if (ticks < 3'(DOT_DASH_THRESH))
      return SYM_DOT;
    else
      return SYM_DASH;
  endfunction

endpackage

// File: rtl/tt_um_ccmed_morse_translator_if.sv
// Bundle of the Tiny Tapeout harness pins; master drives the key side, slave is the design.
interface tt_um_ccmed_morse_translator_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/tt_um_ccmed_morse_translator_rom.sv
// Combinational decode of a dot/dash pattern (first symbol in the MSB of the used bits) to ASCII.
module morse_rom
  import morse_pkg::*;
(
  input  logic [4:0] pattern,
  input  logic [2:0] len,
  output logic [7:0] ascii
);

  logic [4:0] mask;

  always_comb begin
    // len 0 and len > 5 produce an empty mask and fall to the error code.
    mask  = 5'b11111 >> (3'd5 - len);
    ascii = ASCII_ERR;
    case ({len, pattern & mask})
      8'b001_00000: ascii = "E";
      8'b001_00001: ascii = "T";
      8'b010_00000: ascii = "I";
      8'b010_00001: ascii = "A";
      8'b010_00010: ascii = "N";
      8'b010_00011: ascii = "M";
      8'b011_00000: ascii = "S";
      8'b011_00001: ascii = "U";
      8'b011_00010: ascii = "R";
      8'b011_00011: ascii = "W";
      8'b011_00100: ascii = "D";
      8'b011_00101: ascii = "K";
      8'b011_00110: ascii = "G";
      8'b011_00111: ascii = "O";
      8'b100_00000: ascii = "H";
      8'b100_00001: ascii = "V";
      8'b100_00010: ascii = "F";
      8'b100_00100: ascii = "L";
      8'b100_00110: ascii = "P";
      8'b100_00111: ascii = "J";
      8'b100_01000: ascii = "B";
      8'b100_01001: ascii = "X";
      8'b100_01010: ascii = "C";
      8'b100_01011: ascii = "Y";
      8'b100_01100: ascii = "Z";
      8'b100_01101: ascii = "Q";
      8'b101_01111: ascii = "1";
      8'b101_00111: ascii = "2";
      8'b101_00011: ascii = "3";
      8'b101_00001: ascii = "4";
      8'b101_00000: ascii = "5";
      8'b101_10000: ascii = "6";
      8'b101_11000: ascii = "7";
      8'b101_11100: ascii = "8";
      8'b101_11110: ascii = "9";
      8'b101_11111: ascii = "0";
      default:      ascii = ASCII_ERR;
    endcase
  end

endmodule

// File: rtl/tt_um_ccmed_morse_translator.sv
// Morse key to ASCII translator. Define MORSE_SPACE_EN to also emit a space after a word gap.
module tt_um_ccmed_morse_translator
  import morse_pkg::*;
#(
  parameter int DOT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

`ifdef MORSE_SPACE_EN
  localparam bit SPACE_EN = 1'b1;
`else
  localparam bit SPACE_EN = 1'b0;
`endif

  localparam int            PW         = $clog2(DOT_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DOT_CYCLES - 1);

  logic          key_meta, key_sync, key_prev;
  logic [PW-1:0] presc;
  logic [2:0]    press_cnt, len, gap;
  logic [4:0]    pattern;
  logic          ovf, space_armed, char_valid;
  logic [7:0]    char_out, rom_ascii;
  logic          tick, key_edge, key_rise, key_fall;
  logic          gap_run, letter_due, space_due;
  sym_t          sym;

  morse_rom u_rom (
    .pattern (pattern),
    .len     (len),
    .ascii   (rom_ascii)
  );

  // key_edge looks one stage ahead so the prescaler restarts together with the new sync level.
  always_comb begin
    tick       = (presc == PRESC_LAST);
    key_edge   = key_meta ^ key_sync;
    key_rise   = key_sync & ~key_prev;
    key_fall   = ~key_sync & key_prev;
    sym        = classify(press_cnt);
    gap_run    = ~key_sync & tick & ((len != 3'd0) | space_armed);
    letter_due = gap_run & (len != 3'd0) & (gap == 3'(LETTER_GAP - 1));
    space_due  = gap_run & space_armed & (gap == 3'(WORD_GAP - 1));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      key_meta    <= 1'b0;
      key_sync    <= 1'b0;
      key_prev    <= 1'b0;
      presc       <= '0;
      press_cnt   <= '0;
      len         <= '0;
      gap         <= '0;
      pattern     <= '0;
      ovf         <= 1'b0;
      space_armed <= 1'b0;
      char_valid  <= 1'b0;
      char_out    <= '0;
    end else begin
      key_meta   <= ui_in[0];
      key_sync   <= key_meta;
      key_prev   <= key_sync;
      presc      <= (key_edge || tick) ? '0 : presc + 1'b1;
      char_valid <= 1'b0;

      if (key_rise)
        press_cnt <= '0;
      else if (key_sync && tick && press_cnt != PRESS_SAT)
        press_cnt <= press_cnt + 3'd1;

      if (key_sync) begin
        gap         <= '0;
        space_armed <= 1'b0;
      end else if (gap_run) begin
        gap <= gap + 3'd1;
      end

      if (letter_due) begin
        char_out    <= ovf ? ASCII_ERR : rom_ascii;
        char_valid  <= 1'b1;
        pattern     <= '0;
        len         <= '0;
        ovf         <= 1'b0;
        // With spaces enabled the gap keeps running toward the word gap.
        space_armed <= SPACE_EN;
        if (!SPACE_EN)
          gap <= '0;
      end else if (space_due) begin
        char_out    <= ASCII_SPACE;
        char_valid  <= 1'b1;
        space_armed <= 1'b0;
        gap         <= '0;
      end else if (key_fall && sym != SYM_NONE) begin
        if (len == 3'(MAX_SYMBOLS)) begin
          ovf <= 1'b1;
        end else begin
          pattern <= {pattern[3:0], sym == SYM_DASH};
          len     <= len + 3'd1;
        end
      end
    end
  end

  assign uo_out  = char_out;
  assign uio_out = {6'b0, key_sync, char_valid};
  assign uio_oe  = 8'h03;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:1], uio_in};

endmodule

// File: tb/tb_tt_um_ccmed_morse_translator.sv
// Randomized bench for the Morse translator against a string-table reference model.
module tb_tt_um_ccmed_morse_translator;

  localparam int D    = 4;
  localparam int LGAP = 3;
  localparam int WGAP = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  tt_um_ccmed_morse_translator_if pins ();

  tt_um_ccmed_morse_translator #(.DOT_CYCLES(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (pins.ena),
    .ui_in   (pins.ui_in),
    .uo_out  (pins.uo_out),
    .uio_in  (pins.uio_in),
    .uio_out (pins.uio_out),
    .uio_oe  (pins.uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  string codes [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };
  string glyphs = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  string      cur = "";
  logic [7:0] exp_ch [$];
  int         exp_cyc [$];
  logic [7:0] held = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] decode(input string s);
    if (s.len() > 5) return 8'h3F;
    for (int i = 0; i < 36; i++)
      if (codes[i] == s) return glyphs[i];
    return 8'h3F;
  endfunction

  task automatic expect_emit(input logic [7:0] ch, input int at);
    exp_ch.push_back(ch);
    exp_cyc.push_back(at);
  endtask

  // Raw key high for n cycles; a press lasting n cycles is worth n/D ticks.
  task automatic key_high(input int n);
    int k;
    pins.ui_in = {7'($urandom), 1'b1};
    k = cyc;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (cyc == k + 2) check_val("key_sync", 32'(pins.uio_out[1]), 32'd1);
    end
    if (n / D >= 2)      cur = {cur, "-"};
    else if (n / D == 1) cur = {cur, "."};
  endtask

  // Raw key low for m cycles; a pending character is emitted after LGAP ticks of silence,
  // seen two synchronizer cycles plus LGAP*D cycles after the release.
  task automatic key_low(input int m);
    int k;
    int t;
    pins.ui_in = {7'($urandom), 1'b0};
    k = cyc;
    t = m / D;
    if (cur.len() > 0 && t >= LGAP) begin
      expect_emit(decode(cur), k + 2 + LGAP * D);
      cur = "";
`ifdef MORSE_SPACE_EN
      if (t >= WGAP) expect_emit(8'h20, k + 2 + WGAP * D);
`endif
    end
    repeat (m) @(posedge clk);
    #1;
  endtask

  task automatic play(input string code, input int gap, input bit glitch);
    for (int i = 0; i < code.len(); i++) begin
      if (code[i] == "-") key_high($urandom_range(8, 20));
      else                key_high($urandom_range(4, 7));
      if (i < code.len() - 1) begin
        key_low($urandom_range(1, 11));
        if (glitch && i == 0) begin
          key_high($urandom_range(1, 3));
          key_low($urandom_range(1, 11));
        end
      end
    end
    key_low(gap);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      held = 8'h00;
    end else if (pins.uio_out[0]) begin
      if (exp_ch.size() == 0) begin
        check_val("spurious_valid", 32'(pins.uio_out[0]), 32'd0);
      end else begin
        held = exp_ch.pop_front();
        check_val("emit_char", 32'(pins.uo_out), 32'(held));
        check_val("emit_cycle", cyc, exp_cyc.pop_front());
      end
    end else begin
      check_val("hold", 32'(pins.uo_out), 32'(held));
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, got cycle %0d expected under 100000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    r;
    int    g;
    int    nsym;
    string code;

    pins.ena    = 1'b1;
    pins.uio_in = 8'h00;
    pins.ui_in  = 8'h00;
    rst_n       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_uo_out", 32'(pins.uo_out), 32'h00);
    check_val("rst_uio_out", 32'(pins.uio_out), 32'h00);
    check_val("rst_uio_oe", 32'(pins.uio_oe), 32'h03);
    rst_n = 1'b0;
    key_low(8);

    play(".", 12, 1'b0);
    play(".-", 16, 1'b0);
    play("-----", 20, 1'b0);
    play("---", 12, 1'b0);
    play("......", 16, 1'b0);
    play("..--.", 16, 1'b0);
    key_high(2);
    key_low(16);
    play(".", 32, 1'b0);

    // Reset in the middle of a letter gap drops the pending dot.
    key_high(5);
    key_low(6);
    rst_n = 1'b1;
    cur   = "";
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    key_low(40);
    check_val("rst_gap_uo_out", 32'(pins.uo_out), 32'h00);

    // Reset while the key is held drops the press.
    play("-.", 20, 1'b0);
    pins.ui_in = 8'h01;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pins.ui_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    cur   = "";
    key_low(40);
    check_val("rst_press_uo_out", 32'(pins.uo_out), 32'h00);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 9)      g = $urandom_range(28, 40);
      else if (r == 5) g = 12;
      else             g = $urandom_range(12, 27);
      if (r == 6 || r == 7) begin
        code = "";
        nsym = $urandom_range(1, 7);
        for (int j = 0; j < nsym; j++) begin
          if ($urandom_range(0, 1) == 1) code = {code, "-"};
          else                           code = {code, "."};
        end
      end else begin
        code = codes[$urandom_range(0, 35)];
      end
      play(code, g, r == 8);
    end

    repeat (60) @(posedge clk);
    #1;
    check_val("pending_emits", 32'(exp_ch.size()), 32'd0);
    check_val("uio_hi_zero", 32'(pins.uio_out[7:2]), 32'd0);
    check_val("uio_oe_const", 32'(pins.uio_oe), 32'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_um_ccmed_morse_translator.md
TT_UM_CCMED_MORSE_TRANSLATOR -- requirements
Module: tt_um_ccmed_morse_translator

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high.
REQ-002 Parameter DOT_CYCLES, default 1_000_000: clk cycles per Morse time unit ("tick"); legal values are 2 or more.
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port rst_n, input, 1: synchronous reset, asserted when 1; the port keeps the harness name.
REQ-005 Port ena, input, 1: design-select; ignored by the logic.
REQ-006 Port ui_in, input, 8: bit0 = Morse key, 1 = pressed; bits 7:1 unused.
REQ-007 Port uo_out, output, 8: ASCII code of the last emitted character.
REQ-008 Port uio_in, input, 8: unused.
REQ-009 Port uio_out, output, 8: bit0 = char_valid pulse; bit1 = synchronized key level; bits 7:2 = 0.
REQ-010 Port uio_oe, output, 8: constant 8'h03.

Function
REQ-011 The key SHALL pass through a 2-flop synchronizer; all timing SHALL use the synchronized key.
REQ-012 The prescaler SHALL clear on every synchronized key edge and emit a one-cycle tick when it reaches DOT_CYCLES-1, then wrap to 0.
REQ-013 The press counter SHALL count ticks while the key is high, saturating at 7.
REQ-014 On release, a count of 0 SHALL be discarded as a glitch, 1 SHALL add a dot (0), and 2 or more SHALL add a dash (1) to the pattern.
REQ-015 Each symbol SHALL shift into a 5-bit pattern register at the LSB; the 3-bit length SHALL increment.
REQ-016 A 6th symbol SHALL set an overflow flag and leave the pattern unchanged.
REQ-017 The gap counter SHALL count ticks while the key is low and length > 0; a key press SHALL clear it.
REQ-018 When the gap counter reaches 3 ticks, the block SHALL emit one character and then clear the pattern, length, overflow and gap state.
REQ-019 Emit rule: uo_out SHALL be loaded and char_valid SHALL be high for exactly the one clock following the 3rd gap tick.
REQ-020 Emit value, normal case: the ASCII uppercase letter A-Z or digit 0-9 for standard International Morse patterns.
REQ-021 Emit value, error case: overflow, or an unassigned pattern, SHALL emit 0x3F ('?').
REQ-022 uo_out SHALL hold its value between emits.
REQ-023 A key press in the same cycle as an emit SHALL begin a new press; the emit SHALL still complete.

Reset
REQ-024 Reset SHALL clear the synchronizer, prescaler, counters, pattern, length, overflow flag, uo_out (0x00) and char_valid.
REQ-025 Reset mid-symbol or mid-gap SHALL discard the partial character and emit nothing.

Configuration
REQ-026 When MORSE_SPACE_EN is defined, the gap timer SHALL keep counting after an emit.
REQ-027 With MORSE_SPACE_EN, reaching 7 idle ticks with no intervening press SHALL emit 0x20 once, using the same pulse rule as REQ-019.
REQ-028 Without MORSE_SPACE_EN, the block SHALL never emit a space.

Structure
REQ-029 A package morse_pkg SHALL hold the constants DOT_DASH_THRESH=2, LETTER_GAP=3, WORD_GAP=7, MAX_SYMBOLS=5 and ASCII_ERR=8'h3F.
REQ-030 Pattern decode SHALL be a combinational sub-module morse_rom: inputs pattern[4:0] and len[2:0]; output ascii[7:0].

Verification (DOT_CYCLES=4)
REQ-031 Reset -> uo_out=0x00, uio_out=0x00, uio_oe=0x03.
REQ-032 Press 1 tick, release for 3 ticks -> uo_out=0x45 ('E'), char_valid high for exactly 1 cycle.
REQ-033 Dot then dash -> 0x41 ('A'); five dashes -> 0x30 ('0'); three dashes -> 0x4F ('O').
REQ-034 Six dots -> 0x3F; pattern ..--. -> 0x3F.
REQ-035 A 2-cycle key pulse (0 ticks) followed by a 3-tick idle -> no char_valid, uo_out unchanged.
REQ-036 'E' followed by 7 idle ticks -> 0x20 emitted with MORSE_SPACE_EN defined; no second char_valid without it.
